// File: rtl/byte_add_pkg.sv
`default_nettype none
// ============================================================================
// byte_add_pkg : shared constants, state type and sizing helper
// Rev 1.0
// ============================================================================
package byte_add_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Byte-index width; a single-byte operand still needs a 1-bit index.
    function automatic int idx_width(input int nbytes);
        return ($clog2(nbytes) < 1) ? 1 : $clog2(nbytes);
    endfunction

endpackage
`default_nettype wire

// File: rtl/add8_cin.sv
`default_nettype none
// ============================================================================
// add8_cin : combinational 8-bit adder with carry in, {cout,sum} = a+b+cin
// Rev 1.0
// ============================================================================
module add8_cin
    import byte_add_pkg::*;
(
    input  logic [BYTE_W-1:0] a,
    input  logic [BYTE_W-1:0] b,
    input  logic              cin,
    output logic [BYTE_W-1:0] sum,
    output logic              cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{BYTE_W{1'b0}}, cin};

endmodule
`default_nettype wire

// File: rtl/byte_serial_adder.sv
`default_nettype none
// ============================================================================
// byte_serial_adder : wide adder streamed LSB byte first through one add8_cin
// Rev 1.0
// ============================================================================
module byte_serial_adder
    import byte_add_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [8*NBYTES-1:0]      a,
    input  logic [8*NBYTES-1:0]      b,
    input  logic                     cin,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [8*NBYTES-1:0]      sum,
    output logic                     cout,
    output logic                     busy
);

    localparam int                W        = BYTE_W * NBYTES;
    localparam int                IDX_W    = idx_width(NBYTES);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NBYTES - 1);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q,   idx_d;
    logic              carry_q, carry_d;
    logic [W-1:0]      a_q,     a_d;
    logic [W-1:0]      b_q,     b_d;
    logic [W-1:0]      sum_q,   sum_d;
    logic              cout_q,  cout_d;

    logic [BYTE_W-1:0] byte_sum;
    logic              byte_cout;

    // Operands shift down one byte per ADD cycle, so the adder always sees byte 0.
    add8_cin u_add8_cin (
        .a    (a_q[BYTE_W-1:0]),
        .b    (b_q[BYTE_W-1:0]),
        .cin  (carry_q),
        .sum  (byte_sum),
        .cout (byte_cout)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    idx_d   = '0;
                    state_d = ADD;
                end
            end
            ADD: begin
                sum_d[idx_q*BYTE_W +: BYTE_W] = byte_sum;
                carry_d = byte_cout;
                a_d     = a_q >> BYTE_W;
                b_d     = b_q >> BYTE_W;
                if (idx_q == LAST_IDX) begin
                    cout_d  = byte_cout;
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    // in_ready is held low while reset is asserted.
    assign in_ready  = (state_q == IDLE) && rst_n;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == ADD) || (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule
`default_nettype wire

// File: tb/tb_byte_serial_adder.sv
`default_nettype none
// ============================================================================
// tb_byte_serial_adder : directed vector table, corner sequences, random scoreboard
// Rev 1.0
// ============================================================================
module tb_byte_serial_adder;

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        int          stall;
        logic [31:0] exp_sum;
        logic        exp_cout;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        iv4, or4, cin4;
    logic [31:0] a4, b4;
    logic        in_ready4, out_valid4, cout4, busy4;
    logic [31:0] sum4;

    logic        iv1, or1, cin1;
    logic [7:0]  a1, b1;
    logic        in_ready1, out_valid1, cout1, busy1;
    logic [7:0]  sum1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    byte_serial_adder #(.NBYTES(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv4), .in_ready(in_ready4),
        .a(a4), .b(b4), .cin(cin4),
        .out_valid(out_valid4), .out_ready(or4),
        .sum(sum4), .cout(cout4), .busy(busy4)
    );

    byte_serial_adder #(.NBYTES(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv1), .in_ready(in_ready1),
        .a(a1), .b(b1), .cin(cin1),
        .out_valid(out_valid1), .out_ready(or1),
        .sum(sum1), .cout(cout1), .busy(busy1)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Starts and ends on a negedge with the 4-byte DUT idle.
    task automatic do_op4(input vec_t v);
        a4 = v.a; b4 = v.b; cin4 = v.cin; iv4 = 1'b1; or4 = 1'b0;
        chk({v.name, " in_ready before accept"}, in_ready4, 1);
        @(negedge clk);
        iv4 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk({v.name, " out_valid during add"}, out_valid4, 0);
            chk({v.name, " busy during add"}, busy4, 1);
            chk({v.name, " in_ready during add"}, in_ready4, 0);
            a4 = $urandom; b4 = $urandom; cin4 = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        chk({v.name, " out_valid"}, out_valid4, 1);
        chk({v.name, " sum"}, sum4, v.exp_sum);
        chk({v.name, " cout"}, cout4, v.exp_cout);
        for (int s = 0; s < v.stall; s++) begin
            @(negedge clk);
            chk({v.name, " stalled out_valid"}, out_valid4, 1);
            chk({v.name, " stalled in_ready"}, in_ready4, 0);
            chk({v.name, " stalled sum"}, sum4, v.exp_sum);
            chk({v.name, " stalled cout"}, cout4, v.exp_cout);
        end
        or4 = 1'b1;
        @(negedge clk);
        or4 = 1'b0;
        chk({v.name, " out_valid after handshake"}, out_valid4, 0);
        chk({v.name, " in_ready after handshake"}, in_ready4, 1);
        chk({v.name, " busy after handshake"}, busy4, 0);
    endtask

    vec_t vecs[9];

    logic [32:0] q4[$];
    logic [8:0]  q1[$];
    logic [32:0] e4;
    logic [8:0]  e1;
    int acc4, acc1, hs4, hs1, cyc, seen_ov;

    initial begin
        vecs[0] = '{"full_ripple",  32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0, 32'h0000_0000, 1'b1};
        vecs[1] = '{"no_carry",     32'h0000_00FF, 32'h0000_0000, 1'b0, 0, 32'h0000_00FF, 1'b0};
        vecs[2] = '{"cin_ripple",   32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 0, 32'h0000_0000, 1'b1};
        vecs[3] = '{"cin_mixed",    32'h1234_5678, 32'h0FED_CBA8, 1'b1, 0, 32'h2222_2221, 1'b0};
        vecs[4] = '{"backpressure", 32'h8000_0000, 32'h8000_0000, 1'b0, 5, 32'h0000_0000, 1'b1};
        vecs[5] = '{"zeros",        32'h0000_0000, 32'h0000_0000, 1'b0, 1, 32'h0000_0000, 1'b0};
        vecs[6] = '{"msb_into",     32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 0, 32'h8000_0000, 1'b0};
        vecs[7] = '{"all_ones",     32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 2, 32'hFFFF_FFFF, 1'b1};
        vecs[8] = '{"alt_bytes",    32'h00FF_00FF, 32'h0001_0001, 1'b0, 0, 32'h0100_0100, 1'b0};

        rst_n = 1'b0;
        iv4 = 1'b0; or4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
        iv1 = 1'b0; or1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset sum", sum4, 0);
        chk("reset cout", cout4, 0);
        chk("reset out_valid", out_valid4, 0);
        chk("reset busy", busy4, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("in_ready after reset", in_ready4, 1);

        for (int i = 0; i < 9; i++) do_op4(vecs[i]);

        // NBYTES=1: one ADD cycle, behaves as a registered 8-bit adder.
        a1 = 8'hFF; b1 = 8'h01; cin1 = 1'b0; iv1 = 1'b1;
        @(negedge clk);
        iv1 = 1'b0;
        chk("nb1 out_valid during add", out_valid1, 0);
        @(negedge clk);
        chk("nb1 out_valid", out_valid1, 1);
        chk("nb1 sum", sum1, 8'h00);
        chk("nb1 cout", cout1, 1);
        or1 = 1'b1;
        @(negedge clk);
        or1 = 1'b0;
        chk("nb1 in_ready after handshake", in_ready1, 1);

        // in_valid held high: one accept per pass through IDLE.
        a4 = 32'h1111_1111; b4 = 32'h2222_2222; cin4 = 1'b0; iv4 = 1'b1; or4 = 1'b1;
        acc4 = 0; hs4 = 0;
        for (int k = 0; k < 12; k++) begin
            if (in_ready4) acc4++;
            if (out_valid4) hs4++;
            @(negedge clk);
        end
        iv4 = 1'b0; or4 = 1'b0;
        chk("held in_valid accepts", acc4, 2);
        chk("held in_valid handshakes", hs4, 2);
        chk("held in_valid in_ready", in_ready4, 1);
        chk("held in_valid sum", sum4, 32'h3333_3333);

        // Reset pulse in the middle of ADD, away from any clock edge.
        a4 = 32'hFFFF_FFFF; b4 = 32'h0000_0001; cin4 = 1'b0; iv4 = 1'b1;
        @(negedge clk);
        iv4 = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid reset sum", sum4, 0);
        chk("mid reset cout", cout4, 0);
        chk("mid reset out_valid", out_valid4, 0);
        chk("mid reset busy", busy4, 0);
        #3 rst_n = 1'b1;
        seen_ov = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (out_valid4) seen_ov++;
        end
        chk("no out_valid after reset abort", seen_ov, 0);
        chk("in_ready after reset abort", in_ready4, 1);
        do_op4('{"post_reset", 32'h0000_0001, 32'h0000_0001, 1'b0, 0, 32'h0000_0002, 1'b0});

        // Random traffic on both widths with random backpressure.
        acc4 = 0; acc1 = 0; hs4 = 0; hs1 = 0; cyc = 0;
        while ((acc4 < 1000 || acc1 < 1000 || q4.size() != 0 || q1.size() != 0) && cyc < 60000) begin
            @(negedge clk);
            cyc++;
            iv4 = (acc4 < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
            a4 = $urandom; b4 = $urandom; cin4 = 1'($urandom_range(0, 1));
            or4 = (acc4 < 1000) ? ($urandom_range(0, 3) != 0) : 1'b1;
            iv1 = (acc1 < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
            a1 = 8'($urandom); b1 = 8'($urandom); cin1 = 1'($urandom_range(0, 1));
            or1 = (acc1 < 1000) ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (iv4 && in_ready4) begin
                q4.push_back({1'b0, a4} + {1'b0, b4} + {32'd0, cin4});
                acc4++;
            end
            if (iv1 && in_ready1) begin
                q1.push_back({1'b0, a1} + {1'b0, b1} + {8'd0, cin1});
                acc1++;
            end
            if (out_valid4 && or4) begin
                hs4++;
                if (q4.size() == 0) chk("rand4 unexpected result", 1, 0);
                else begin
                    e4 = q4.pop_front();
                    chk("rand4 {cout,sum}", {cout4, sum4}, e4);
                end
            end
            if (out_valid1 && or1) begin
                hs1++;
                if (q1.size() == 0) chk("rand1 unexpected result", 1, 0);
                else begin
                    e1 = q1.pop_front();
                    chk("rand1 {cout,sum}", {cout1, sum1}, e1);
                end
            end
        end
        iv4 = 1'b0; iv1 = 1'b0; or4 = 1'b0; or1 = 1'b0;
        chk("rand cycle budget", cyc < 60000, 1);
        chk("rand4 accepts vs handshakes", acc4, hs4);
        chk("rand1 accepts vs handshakes", acc1, hs1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
